// File: rtl/boson_capture_ctrl.sv
// Boson CMOS video port frame capture sequencer.
// Arms on capture_req, aligns to a clean VSYNC rising edge, then turns the
// VALID-qualified pixel stream into addressed frame-buffer writes.
//
// Ports:
//   clk, reset_n      pixel clock, async active-low reset
//   cmos_vsync        high during the active frame region
//   cmos_hsync        line sync (observed only; line ends come from VALID)
//   cmos_valid        pixel qualifier
//   cmos_dq           pixel data
//   capture_req       one-cycle arm pulse, honoured only in IDLE
//   continuous        re-arm for the next frame when sampled in DONE
//   abort             level, forces IDLE
//   wr_en/addr/data   frame-buffer write port, one write per clock max
//   busy              state != IDLE
//   frame_done        one-cycle pulse per completed frame
//   line_err          sticky: a line had a pixel count != H_ACTIVE
//   frame_err         sticky: VSYNC fell before V_ACTIVE lines
//   line_count        lines captured in the last/current frame

`timescale 1ns/1ps

module boson_capture_ctrl #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 256,
    parameter int ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmos_vsync,
    input  logic              cmos_hsync,
    input  logic              cmos_valid,
    input  logic [15:0]       cmos_dq,
    input  logic              capture_req,
    input  logic              continuous,
    input  logic              abort,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err,
    output logic [15:0]       line_count
);

    localparam int PIX_W = $clog2(H_ACTIVE + 1);

    localparam logic [PIX_W-1:0]  H_PIX  = PIX_W'(H_ACTIVE);
    localparam logic [ADDR_W-1:0] H_ADDR = ADDR_W'(H_ACTIVE);
    localparam logic [15:0]       V_LINE = 16'(V_ACTIVE);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_VS_LOW,
        WAIT_VS_HIGH,
        CAPTURE,
        DONE
    } state_t;

    state_t state;

    // Input register stage and the previous registered value for edges.
    logic        vs_q;
    logic        vs_prev;
    logic        val_q;
    logic        val_prev;
    logic [15:0] dq_q;

    logic [PIX_W-1:0]  pix;
    logic [15:0]       line;
    logic [ADDR_W-1:0] line_base;

    logic        vs_rise;
    logic        vs_fall;
    logic        val_fall;
    logic [15:0] line_nxt;

    // HSYNC is only brought in so it can be probed; line boundaries are
    // taken from the falling edge of VALID, which is what Boson guarantees.
    logic hsync_unused;
    assign hsync_unused = cmos_hsync;

    assign vs_rise  = vs_q & ~vs_prev;
    assign vs_fall  = ~vs_q & vs_prev;
    assign val_fall = ~val_q & val_prev;
    assign line_nxt = line + 16'd1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            vs_q       <= 1'b0;
            vs_prev    <= 1'b0;
            val_q      <= 1'b0;
            val_prev   <= 1'b0;
            dq_q       <= '0;
            pix        <= '0;
            line       <= '0;
            line_base  <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            line_count <= '0;
        end else begin
            vs_q     <= cmos_vsync;
            vs_prev  <= vs_q;
            val_q    <= cmos_valid;
            val_prev <= val_q;
            dq_q     <= cmos_dq;

            wr_en      <= 1'b0;
            frame_done <= 1'b0;

            // abort outranks everything, including a same-cycle request
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (capture_req) begin
                            line_err   <= 1'b0;
                            frame_err  <= 1'b0;
                            line_count <= '0;
                            pix        <= '0;
                            line       <= '0;
                            line_base  <= '0;
                            busy       <= 1'b1;
                            state      <= WAIT_VS_LOW;
                        end
                    end

                    // Never start mid-frame: see VSYNC low first.
                    WAIT_VS_LOW: begin
                        if (!vs_q) begin
                            state <= WAIT_VS_HIGH;
                        end
                    end

                    WAIT_VS_HIGH: begin
                        if (vs_rise) begin
                            pix       <= '0;
                            line      <= '0;
                            line_base <= '0;
                            state     <= CAPTURE;
                        end
                    end

                    CAPTURE: begin
                        if (val_q) begin
                            if (pix < H_PIX) begin
                                wr_en   <= 1'b1;
                                wr_addr <= line_base + ADDR_W'(pix);
                                wr_data <= dq_q;
                                pix     <= pix + PIX_W'(1);
                            end else begin
                                // overlong line: drop, pix stays saturated
                                line_err <= 1'b1;
                            end
                        end

                        if (val_fall) begin
                            if (pix != H_PIX) begin
                                line_err <= 1'b1;
                            end
                            pix        <= '0;
                            line       <= line_nxt;
                            line_count <= line_nxt;
                            // every line starts at its own base, even
                            // after a short one
                            line_base  <= line_base + H_ADDR;
                        end

                        // completion wins over a coincident VSYNC fall
                        if (val_fall && line_nxt == V_LINE) begin
                            state <= DONE;
                        end else if (vs_fall) begin
                            frame_err <= 1'b1;
                            state     <= DONE;
                        end
                    end

                    DONE: begin
                        frame_done <= 1'b1;
                        if (continuous) begin
                            pix       <= '0;
                            line      <= '0;
                            line_base <= '0;
                            state     <= WAIT_VS_LOW;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boson_capture_ctrl.sv
// Scoreboard bench for boson_capture_ctrl: the stimulus pushes expected
// writes, a monitor pops and compares whenever wr_en is seen.

`timescale 1ns/1ps

module tb_boson_capture_ctrl;

    localparam int H  = 320;
    localparam int V  = 12;
    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmos_vsync = 1'b0;
    logic          cmos_hsync = 1'b0;
    logic          cmos_valid = 1'b0;
    logic [15:0]   cmos_dq = '0;
    logic          capture_req = 1'b0;
    logic          continuous = 1'b0;
    logic          abort = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          busy;
    logic          frame_done;
    logic          line_err;
    logic          frame_err;
    logic [15:0]   line_count;

    always #5 clk = ~clk;

    boson_capture_ctrl #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .ADDR_W  (AW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmos_vsync (cmos_vsync),
        .cmos_hsync (cmos_hsync),
        .cmos_valid (cmos_valid),
        .cmos_dq    (cmos_dq),
        .capture_req(capture_req),
        .continuous (continuous),
        .abort      (abort),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_err  (frame_err),
        .line_count (line_count)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  done_cnt = 0;
    int  len_tab[0:15];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({wr_en, wr_addr, wr_data, busy, frame_done,
                    line_err, frame_err, line_count});
    endfunction

    // Monitor: sample 1ns after the rising edge.
    always @(posedge clk) begin
        wr_t e;
        #1;
        if (frame_done) done_cnt++;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%0h",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(e.addr));
                check("wr_data", 64'(wr_data), 64'(e.data));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic arm();
        @(negedge clk);
        capture_req = 1'b1;
        @(negedge clk);
        capture_req = 1'b0;
    endtask

    // One VSYNC frame. armed: writes are expected from line 0.
    // req_line: pulse capture_req at the start of that line.
    // cut_line/cut_pix: abort (or reset if cut_rst) as that pixel is
    // driven; the pixel before it is still in the input register and is
    // lost, so only pixels < cut_pix-1 of that line are written.
    task automatic frame(input int nlines, input bit armed,
                         input int req_line, input int cut_line,
                         input int cut_pix, input bit cut_rst);
        bit  live = armed;
        wr_t w;
        @(negedge clk);
        cmos_vsync = 1'b1;
        @(negedge clk);
        for (int l = 0; l < nlines; l++) begin
            for (int p = 0; p < len_tab[l]; p++) begin
                @(negedge clk);
                capture_req = (l == req_line && p == 0);
                cmos_valid  = 1'b1;
                cmos_hsync  = 1'b0;
                cmos_dq     = 16'($urandom);
                if (live && p < H && l < V &&
                    !(l == cut_line && p >= cut_pix - 1)) begin
                    w.addr = AW'(l * H + p);
                    w.data = cmos_dq;
                    exp_q.push_back(w);
                end
                if (l == cut_line && p == cut_pix) begin
                    live = 1'b0;
                    if (cut_rst) begin
                        reset_n = 1'b0;
                        #1;
                        check("reset_mid_line_outs", all_outs(), 64'd0);
                    end else begin
                        abort = 1'b1;
                    end
                end
                if (l == cut_line && p == cut_pix + 3) begin
                    reset_n = 1'b1;
                    abort   = 1'b0;
                end
            end
            for (int b = 0; b < 3; b++) begin
                @(negedge clk);
                cmos_valid  = 1'b0;
                capture_req = 1'b0;
                cmos_hsync  = (b == 0);
            end
        end
        @(negedge clk);
        cmos_vsync = 1'b0;
        cmos_hsync = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) len_tab[i] = H;

        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", all_outs(), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // Nominal frame plus an extra line beyond V that must be ignored.
        arm();
        #1;
        check("busy_after_req", 64'(busy), 64'd1);
        frame(13, 1'b1, -1, -1, 0, 1'b0);
        check("nom_done", 64'(done_cnt), 64'd1);
        check("nom_line_count", 64'(line_count), 64'(V));
        check("nom_flags", 64'({line_err, frame_err}), 64'd0);
        check("nom_busy", 64'(busy), 64'd0);
        check("nom_drain", 64'(exp_q.size()), 64'd0);

        // Request mid-frame: nothing until the next VSYNC rise.
        frame(V, 1'b0, 6, -1, 0, 1'b0);
        check("mid_busy_waiting", 64'(busy), 64'd1);
        check("mid_no_done", 64'(done_cnt), 64'd1);
        frame(V, 1'b1, -1, -1, 0, 1'b0);
        check("mid_done", 64'(done_cnt), 64'd2);
        check("mid_line_count", 64'(line_count), 64'(V));
        check("mid_drain", 64'(exp_q.size()), 64'd0);

        // Long line 5 (321) and short line 6 (319).
        len_tab[5] = H + 1;
        len_tab[6] = H - 1;
        arm();
        frame(V, 1'b1, -1, -1, 0, 1'b0);
        len_tab[5] = H;
        len_tab[6] = H;
        check("ls_line_err", 64'(line_err), 64'd1);
        check("ls_frame_err", 64'(frame_err), 64'd0);
        check("ls_done", 64'(done_cnt), 64'd3);
        check("ls_drain", 64'(exp_q.size()), 64'd0);

        // Truncated frame: VSYNC falls after 5 lines.
        arm();
        frame(5, 1'b1, -1, -1, 0, 1'b0);
        check("tr_done", 64'(done_cnt), 64'd4);
        check("tr_frame_err", 64'(frame_err), 64'd1);
        check("tr_line_err", 64'(line_err), 64'd0);
        check("tr_line_count", 64'(line_count), 64'd5);
        check("tr_last_addr", 64'(wr_addr), 64'd1599);
        check("tr_drain", 64'(exp_q.size()), 64'd0);

        // Continuous: two frames, then drop it; third frame not captured.
        continuous = 1'b1;
        arm();
        frame(V, 1'b1, -1, -1, 0, 1'b0);
        continuous = 1'b0;
        check("ct_done1", 64'(done_cnt), 64'd5);
        check("ct_busy1", 64'(busy), 64'd1);
        frame(V, 1'b1, -1, -1, 0, 1'b0);
        check("ct_done2", 64'(done_cnt), 64'd6);
        check("ct_busy2", 64'(busy), 64'd0);
        frame(V, 1'b0, -1, -1, 0, 1'b0);
        check("ct_done_after", 64'(done_cnt), 64'd6);
        check("ct_flags", 64'({line_err, frame_err}), 64'd0);
        check("ct_drain", 64'(exp_q.size()), 64'd0);

        // Abort at line 5, pixel 10.
        arm();
        frame(V, 1'b1, -1, 5, 10, 1'b0);
        check("ab_no_done", 64'(done_cnt), 64'd6);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_line_count", 64'(line_count), 64'd5);
        check("ab_drain", 64'(exp_q.size()), 64'd0);

        // abort together with capture_req: abort wins.
        @(negedge clk);
        abort       = 1'b1;
        capture_req = 1'b1;
        @(negedge clk);
        abort       = 1'b0;
        capture_req = 1'b0;
        check("ab_req_busy", 64'(busy), 64'd0);

        // Reset mid-line (line 3, pixel 20), then a clean frame.
        arm();
        frame(V, 1'b1, -1, 3, 20, 1'b1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_line_count", 64'(line_count), 64'd0);
        check("rst_drain", 64'(exp_q.size()), 64'd0);
        arm();
        frame(V, 1'b1, -1, -1, 0, 1'b0);
        check("rst_done", 64'(done_cnt), 64'd7);
        check("rst_line_count2", 64'(line_count), 64'(V));
        check("rst_flags", 64'({line_err, frame_err}), 64'd0);
        check("rst_drain2", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
